// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore control unit for the multicycle RV32I core. A single state register
// sequences the shared datapath (ALU, unified memory, register bank,
// extender) across 3-5 cycles per instruction. Every output is a
// combinational function of the state register and the instruction fields.
// The current state is exported on State so checkers can follow the FSM.
//
// There is no valid/ready handshake on this block: the instruction fields
// are assumed stable from the instruction register once FETCH has written
// it, and Zero is only consulted in the BEQ cycle.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       Illegal
);

  // State encoding (legacy numeric codes, exported on State).
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  // Supported opcodes.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALUOp classes handed from the main FSM to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Mux select encodings.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_BAD = 3'b111;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Raw per-state controls before reset gating.
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       adr_src;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       trap_st;

  // State register: the only storage in the block; async reset to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused codes 12-15 recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE: state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECR;
          OP_ITYPE: state_d = S_EXECI;
          OP_JAL:   state_d = S_JAL;
          OP_BEQ:   state_d = S_BEQ;
          default:  state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode: one set of datapath controls per state.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = ALUOP_ADD;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    trap_st       = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Read instruction at PC and compute PC+4 in the same cycle.
        ir_write_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        pc_update    = 1'b1;
        alu_op       = ALUOP_ADD;
      end
      S_DECODE: begin
        // Speculatively form the branch/jump target OldPC + imm.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        // Writes ALUOut: the ALU result, or OldPC+4 for jal.
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut; ALU forms OldPC+4 for rd.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_TRAP: begin
        trap_st = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Immediate format depends only on the opcode, in every state.
  always_comb begin
    case (op)
      OP_STORE: ImmSrc = IMM_S;
      OP_BEQ:   ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      default:  ImmSrc = IMM_I;
    endcase
  end

  // ALU decoder: sub only for R-type with funct7b5 set, never for addi.
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_BAD;
        endcase
      end
      default:   ALUControl = ALU_BAD;
    endcase
  end

  // Write enables are gated directly by rst so they drop without a clock.
  always_comb begin
    PCWrite   = ~rst & (pc_update | (branch & Zero));
    IRWrite   = ~rst & ir_write_raw;
    MemWrite  = ~rst & mem_write_raw;
    RegWrite  = ~rst & reg_write_raw;
    Illegal   = ~rst & trap_st;
    AdrSrc    = adr_src;
    ResultSrc = result_src;
    ALUSrcA   = alu_src_a;
    ALUSrcB   = alu_src_b;
    State     = state_q;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks lw, sw, R-type, addi,
// beq, jal and an illegal opcode through the FSM, plus asynchronous reset
// in mid-instruction and in TRAP. Expected control words are hand-written.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic       Illegal;

  int vectors = 0;
  int miscompares = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .State      (State),
    .Illegal    (Illegal)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,
  // ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}.
  logic [16:0] ctrl_w;
  assign ctrl_w = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check State and the full control word against hand-written fields.
  task automatic expect_ctrl(input string tag, input logic [3:0] st,
                             input logic pcw, input logic adr, input logic mw,
                             input logic irw, input logic rw,
                             input logic [1:0] res, input logic [1:0] sa,
                             input logic [1:0] sb, input logic [1:0] imm,
                             input logic [2:0] alu, input logic ill);
    #1;
    chk({tag, ".state"}, {13'd0, State}, {13'd0, st});
    chk({tag, ".ctrl"}, ctrl_w, {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill});
  endtask

  initial begin
    rst = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;

    // Held in reset: FETCH selects, all enables low.
    repeat (2) @(posedge clk);
    #1;
    expect_ctrl("rst_hold", 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);

    // Release mid-cycle: FETCH enables appear.
    #2 rst = 1'b0;
    expect_ctrl("rel_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);

    // lw: 0,1,2,3,4,0
    tick(); expect_ctrl("lw_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000, 0);
    tick(); expect_ctrl("lw_memadr", 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000, 0);
    tick(); expect_ctrl("lw_memread", 4'd3, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000, 0);
    tick(); expect_ctrl("lw_memwb", 4'd4, 0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,3'b000, 0);
    tick(); expect_ctrl("lw_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);

    // lw again, reset asynchronously inside MEMREAD.
    tick(); tick(); tick();
    expect_ctrl("lw2_memread", 4'd3, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000, 0);
    #1 rst = 1'b1;
    expect_ctrl("rst_mid", 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);
    op = 7'b0100011;
    #1 rst = 1'b0;
    expect_ctrl("sw_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01,3'b000, 0);

    // sw: 0,1,2,5,0
    tick(); expect_ctrl("sw_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000, 0);
    tick(); expect_ctrl("sw_memadr", 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000, 0);
    tick(); expect_ctrl("sw_memwrite", 4'd5, 0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000, 0);
    tick();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    expect_ctrl("r_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);

    // R-type: 0,1,6,7,0 with ALU decode sweep inside EXECR.
    tick(); expect_ctrl("r_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000, 0);
    tick(); expect_ctrl("r_sub", 4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b001, 0);
    funct7b5 = 1'b0; #1 chk("r_add", {14'd0, ALUControl}, 17'd0);
    funct3 = 3'b111; #1 chk("r_and", {14'd0, ALUControl}, {14'd0, 3'b010});
    funct3 = 3'b110; #1 chk("r_or",  {14'd0, ALUControl}, {14'd0, 3'b011});
    funct3 = 3'b010; #1 chk("r_slt", {14'd0, ALUControl}, {14'd0, 3'b101});
    funct3 = 3'b001; #1 chk("r_bad", {14'd0, ALUControl}, {14'd0, 3'b111});
    tick(); expect_ctrl("r_aluwb", 4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000, 0);
    tick();
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;

    // addi with funct7b5 set must still add: 0,1,8,7,0
    tick(); expect_ctrl("i_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000, 0);
    tick(); expect_ctrl("i_addi", 4'd8, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000, 0);
    funct3 = 3'b010; #1 chk("i_slti", {14'd0, ALUControl}, {14'd0, 3'b101});
    tick(); expect_ctrl("i_aluwb", 4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000, 0);
    tick(); expect_ctrl("i_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);

    // beq: Zero ignored outside BEQ; PCWrite follows Zero in BEQ.
    op = 7'b1100011; Zero = 1'b1;
    tick(); expect_ctrl("b_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000, 0);
    tick(); expect_ctrl("b_taken", 4'd10, 1,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001, 0);
    Zero = 1'b0;
    expect_ctrl("b_nottaken", 4'd10, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001, 0);
    op = 7'b1101111;
    tick(); expect_ctrl("j_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b11,3'b000, 0);

    // jal: 0,1,9,7,0
    tick(); expect_ctrl("j_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11,3'b000, 0);
    tick(); expect_ctrl("j_jal", 4'd9, 1,0,0,0,0, 2'b00,2'b01,2'b10,2'b11,3'b000, 0);
    tick(); expect_ctrl("j_aluwb", 4'd7, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11,3'b000, 0);
    tick();
    op = 7'b0000000;
    expect_ctrl("x_fetch", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);

    // Illegal opcode: TRAP is sticky with no enables.
    tick(); expect_ctrl("x_decode", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000, 0);
    for (int i = 0; i < 20; i++) begin
      Zero = i[0];
      tick();
      expect_ctrl("x_trap", 4'd11, 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000, 1);
    end

    // Asynchronous reset out of TRAP.
    #1 rst = 1'b1;
    expect_ctrl("x_rst", 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);
    op = 7'b0000011;
    #1 rst = 1'b0;
    expect_ctrl("x_release", 4'd0, 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000, 0);
    tick(); expect_ctrl("x_decode2", 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle variant of the RV32I core. A Moore state machine sequences the shared datapath (one ALU, one unified instruction/data memory, register bank, extender) across 3–5 cycles per instruction. It emits the mux selects, write enables and ALU control that the single-cycle core derives combinationally. Supports lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal; any other opcode traps.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  Instr[6:0], taken from the instruction register.
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU result == 0.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register (and OldPC) enable.
- RegWrite  out  1  register bank WE3.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 unsupported.
- State  out  4  current state code, for debug and verification.
- Illegal  out  1  high while the FSM is in the trap state.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11. Codes 12–15 go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BEQ; anything else → TRAP.
  - MEMADR → MEMREAD if op[5] = 0, else → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR and EXECI → ALUWB.
  - JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
  - TRAP → TRAP until rst.
- Per-state outputs (unlisted outputs are 0; selects are 00):
  - FETCH: IRWrite = 1, ALUSrcB = 10, ResultSrc = 10, PCUpdate = 1, ALUOp = 00.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00.
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00.
  - MEMREAD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - MEMWRITE: AdrSrc = 1, MemWrite = 1.
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10.
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10.
  - ALUWB: RegWrite = 1.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, PCUpdate = 1.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, Branch = 1.
  - TRAP: all enables 0, Illegal = 1.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is decoded from op in every state:
  - 0100011 → 01; 1100011 → 10; 1101111 → 11; otherwise 00.
- ALU decoder:
  - ALUOp 00 → 000; ALUOp 01 → 001.
  - ALUOp 10 with funct3 000 → 001 if (op[5] & funct7b5), else 000.
  - ALUOp 10 with funct3 010 → 101; 110 → 011; 111 → 010; other funct3 → 111.
- The instruction still completes when ALUControl = 111; the datapath ALU produces its error value.

## Timing
- The state register is the only sequential element. All outputs are combinational from the state register and the op/funct inputs; there are no registered outputs.
- While rst = 1:
  - State = 0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0, gated combinationally by rst.
  - Illegal = 0.
  - The remaining outputs take their FETCH values.
- The first FETCH write occurs on the first rising edge after rst falls.
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- Assertion of rst in any state, including TRAP and mid-instruction, forces State = 0 and zero write enables immediately, without waiting for a clock edge.
- The beq decision uses Zero sampled in the BEQ cycle only.

## Test plan
- Reset: assert rst mid-cycle with no clk edge → State = 0 and PCWrite = IRWrite = MemWrite = RegWrite = 0 immediately; release → FETCH asserts IRWrite = 1, PCWrite = 1.
- lw (op 0000011): State 0, 1, 2, 3, 4, 0. AdrSrc = 1 in state 3; RegWrite = 1 with ResultSrc = 01 in state 4; MemWrite is never asserted.
- R-type sub (op 0110011, funct3 000, funct7b5 = 1): EXECR gives ALUControl = 001. With funct7b5 = 0: 000. With funct3 = 111: 010. With funct3 = 110: 011. With funct3 = 010: 101.
- addi with funct7b5 = 1 (op 0010011): ALUControl = 000, not sub. sw: ImmSrc = 01 and MemWrite = 1 in state 5 only; 4 cycles.
- beq (op 1100011) with Zero = 1 → PCWrite = 1 in state 10; with Zero = 0 → PCWrite = 0. Returns to FETCH after 3 cycles. jal: ImmSrc = 11, PCWrite in state 9, RegWrite in state 7.
- Illegal op 0000000 → TRAP (11) after DECODE; Illegal = 1 and no enables over 20 cycles. rst then returns State to 0 and Illegal to 0.
